exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Execution sequencer for the single-cycle MIPS on the Basys board. Sits between the debounced button pulses and the program counter / instruction-source mux, and decides when one instruction commits and where it comes from. Supports single-step, free-running at a divided rate, switch-sourced instruction injection, and a terminal halt. Owns the retired-instruction counter shown in debug.

## Interface

- `TICK_DIV`, 50_000_000: clock cycles between issues in RUN mode; must be ≥ 2.
- `ADDR_W`, 5: instruction-address width.
- `CNT_W`, 16: retired-instruction counter width.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock; takes priority over every other input.
- `stepPulse` in 1: one-cycle debounced pulse; execute one instruction from instruction memory.
- `runPulse` in 1: one-cycle pulse; toggles RUN/IDLE and resumes from BREAK.
- `basysPulse` in 1: one-cycle pulse; execute the instruction on the switches.
- `halt` in 1: halt decode of the currently selected instruction (combinational from the core).
- `currentInstructionAddress` in ADDR_W: PC value.
- `breakAddress` in ADDR_W: breakpoint address; present only with `EXEC_BREAKPOINT_EN`.
- `execEnable` out 1: registered one-cycle commit strobe to the PC and the core's write enables.
- `useBasys` out 1: registered instruction-source select; 1 selects the switches.
- `state` out 3: current `exec_state_t`.
- `instrCount` out CNT_W: number of execEnable strobes, saturating.

## Operation

- States: IDLE=0, RUN=1, HALTED=2, BREAK=3, BASYS=4.
- Decision priority within one cycle: reset > halt check > runPulse > stepPulse > basysPulse.
- A memory-sourced issue is evaluated with `halt`.
  - halt=1: no strobe; go to HALTED.
  - halt=0: `execEnable`=1 on the next cycle.
- IDLE:
  - stepPulse → evaluate an issue; stay in IDLE.
  - runPulse → RUN; tick counter cleared.
  - basysPulse → BASYS.
- BASYS:
  - `useBasys`=1 while in this state and for the following strobe cycle.
  - `halt` is evaluated in BASYS: halt=0 gives a strobe, then IDLE; halt=1 gives no strobe, then HALTED.
  - Pulses arriving in BASYS are dropped.
- RUN:
  - Tick counter runs 0..TICK_DIV-1 and wraps; at TICK_DIV-1 an issue is evaluated.
  - runPulse → IDLE, counter cleared; a tick coinciding with runPulse does not issue.
  - stepPulse and basysPulse are ignored.
- HALTED: all pulses ignored; `execEnable`=0; left only by reset.
- BREAK: see Configuration.
- `instrCount` increments on each `execEnable` cycle and saturates at 2^CNT_W−1.

## Timing

- Reset values: state=IDLE, `execEnable`=0, `useBasys`=0, `instrCount`=0, tick counter=0, skip flag=0.
- stepPulse at cycle N (IDLE): `execEnable` high at N+1 only.
- basysPulse at N:
  - state=BASYS and `useBasys`=1 at N+1; `halt` is sampled at N+1.
  - `execEnable`=1 with `useBasys`=1 at N+2.
  - `useBasys`=0 and state=IDLE at N+3.
- runPulse at N: state=RUN at N+1; first strobe at N+1+TICK_DIV; subsequent strobes every TICK_DIV cycles.
- `execEnable` is never high on two consecutive cycles.
- Reset during BASYS or mid-RUN: the next cycle is the full reset state; a pending strobe is cancelled.

## Configuration

- Feature macro: `EXEC_BREAKPOINT_EN`.
- Defined:
  - `breakAddress` port and the BREAK state exist.
  - In RUN, at a tick where `currentInstructionAddress`==`breakAddress` and the skip flag is 0: no strobe; go to BREAK.
  - In BREAK, runPulse → RUN with the skip flag set. The skip flag clears on the next strobe, so the breakpoint instruction executes once.
  - In BREAK, stepPulse → evaluate one issue, then IDLE.
  - In BREAK, basysPulse is ignored.
- Undefined: no port, no BREAK state, no skip flag; state encoding 3 is unused.

## Structure

- Package `exec_pkg`:
  - `exec_state_t` enum (3-bit, values above).
  - `EXEC_ADDR_W` and `EXEC_CNT_W` default constants.
- Sub-module `tick_divider`:
  - Parameter `TICK_DIV`; inputs `clk`, `reset`, `clear`, `enable`; output `tick`.
  - `tick` is a one-cycle pulse at count TICK_DIV-1.

## Test plan (TICK_DIV=4)

- Reset, then stepPulse with halt=0 → exactly one `execEnable` the next cycle; `instrCount`=1; state=0.
- basysPulse at N → `useBasys`=1 at N+1..N+2; `execEnable` only at N+2; state back to 0 at N+3.
- runPulse, halt=0 for 20 cycles → strobes at N+5, N+9, N+13, N+17; runPulse again → state=0 and no further strobes.
- RUN, halt raised before the 3rd tick → exactly 2 strobes; state=2; step, run and basys pulses then give no strobe; reset → all outputs reset.
- `EXEC_BREAKPOINT_EN`, breakAddress=3, PC advancing 0,1,2,3 → state=3 with PC=3 and no strobe at that tick; runPulse → PC=3 executes and RUN continues.
- Preload `instrCount`=0xFFFF via a forced run → further strobes leave it at 0xFFFF; reset asserted during BASYS → no strobe at N+2.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and defaults for the execution sequencer.
// Provides exec_state_t (BREAK only with EXEC_BREAKPOINT_EN) and width defaults.
package exec_pkg;

    localparam int EXEC_ADDR_W = 5;
    localparam int EXEC_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        HALTED = 3'd2,
`ifdef EXEC_BREAKPOINT_EN
        BREAK  = 3'd3,
`endif
        BASYS  = 3'd4
    } exec_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running issue-rate divider for RUN mode.
// Ports: clk, reset (sync, high), clear, enable in; tick out (one cycle at count TICK_DIV-1).
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Commit sequencer: step, divided free-run, switch injection, terminal halt.
// Ports: clk, reset, stepPulse, runPulse, basysPulse, halt, currentInstructionAddress,
// breakAddress (EXEC_BREAKPOINT_EN only) in; execEnable, useBasys, state, instrCount out.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int ADDR_W   = EXEC_ADDR_W,
    parameter int CNT_W    = EXEC_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stepPulse,
    input  logic              runPulse,
    input  logic              basysPulse,
    input  logic              halt,
    input  logic [ADDR_W-1:0] currentInstructionAddress,
`ifdef EXEC_BREAKPOINT_EN
    input  logic [ADDR_W-1:0] breakAddress,
`endif
    output logic              execEnable,
    output logic              useBasys,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  instrCount
);

    exec_state_t curState;
    exec_state_t nextState;
    logic        nextExec;
    logic        nextUseBasys;
    logic        issueReq;
    logic        breakHit;
    logic        tick;
    logic        tickClear;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) uTick (
        .clk   (clk),
        .reset (reset),
        .clear (tickClear),
        .enable(curState == RUN),
        .tick  (tick)
    );

    // Counter restarts from zero on every entry into RUN and when RUN is left.
    assign tickClear = (curState != RUN) || runPulse;

`ifdef EXEC_BREAKPOINT_EN
    logic skip;
    logic nextSkip;

    assign breakHit = (currentInstructionAddress == breakAddress) && !skip;

    always_ff @(posedge clk) begin
        if (reset) begin
            skip <= 1'b0;
        end else begin
            skip <= nextSkip;
        end
    end
`else
    logic unusedPc;

    assign unusedPc = ^currentInstructionAddress;
    assign breakHit = 1'b0;
`endif

    always_comb begin
        nextState    = curState;
        nextExec     = 1'b0;
        nextUseBasys = 1'b0;
        issueReq     = 1'b0;
`ifdef EXEC_BREAKPOINT_EN
        nextSkip     = skip;
`endif
        unique case (curState)
            IDLE: begin
                if (runPulse) begin
                    nextState = RUN;
                end else if (stepPulse) begin
                    // A step landing on a strobe cycle would give back-to-back commits.
                    issueReq = !execEnable;
                end else if (basysPulse) begin
                    nextState    = BASYS;
                    nextUseBasys = 1'b1;
                end
            end
            RUN: begin
                // A halting tick wins over runPulse; otherwise runPulse cancels the tick.
                if (tick && !breakHit && (halt || !runPulse)) begin
                    issueReq = 1'b1;
                end else if (runPulse) begin
                    nextState = IDLE;
`ifdef EXEC_BREAKPOINT_EN
                end else if (tick) begin
                    nextState = BREAK;
`endif
                end
            end
            HALTED: begin
                nextState = HALTED;
            end
`ifdef EXEC_BREAKPOINT_EN
            BREAK: begin
                if (runPulse) begin
                    nextState = RUN;
                    nextSkip  = 1'b1;
                end else if (stepPulse) begin
                    nextState = IDLE;
                    issueReq  = 1'b1;
                end
            end
`endif
            BASYS: begin
                nextState    = IDLE;
                issueReq     = 1'b1;
                nextUseBasys = 1'b1;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        if (issueReq) begin
            if (halt) begin
                nextState    = HALTED;
                nextUseBasys = 1'b0;
            end else begin
                nextExec = 1'b1;
`ifdef EXEC_BREAKPOINT_EN
                nextSkip = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            curState   <= IDLE;
            execEnable <= 1'b0;
            useBasys   <= 1'b0;
        end else begin
            curState   <= nextState;
            execEnable <= nextExec;
            useBasys   <= nextUseBasys;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instrCount <= '0;
        end else if (execEnable && (instrCount != '1)) begin
            instrCount <= instrCount + 1'b1;
        end
    end

    assign state = curState;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer at TICK_DIV=4, small counter width.
// Expected strobe cycles are queued at stimulus time and popped by a negedge monitor.
module tb_exec_sequencer;

    import exec_pkg::*;

    localparam int TD = 4;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int P_STEP  = 0;
    localparam int P_RUN   = 1;
    localparam int P_BASYS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stepPulse = 1'b0;
    logic          runPulse = 1'b0;
    logic          basysPulse = 1'b0;
    logic          halt = 1'b0;
    logic [AW-1:0] pc;
`ifdef EXEC_BREAKPOINT_EN
    logic [AW-1:0] brk = 5'd31;
`endif
    logic          execEnable;
    logic          useBasys;
    logic [2:0]    state;
    logic [CW-1:0] instrCount;

    exec_sequencer #(
        .TICK_DIV(TD),
        .ADDR_W  (AW),
        .CNT_W   (CW)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .stepPulse                (stepPulse),
        .runPulse                 (runPulse),
        .basysPulse               (basysPulse),
        .halt                     (halt),
        .currentInstructionAddress(pc),
`ifdef EXEC_BREAKPOINT_EN
        .breakAddress             (brk),
`endif
        .execEnable               (execEnable),
        .useBasys                 (useBasys),
        .state                    (state),
        .instrCount               (instrCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the core's PC: advances on each commit.
    always @(posedge clk) begin
        if (reset) pc <= '0;
        else if (execEnable) pc <= pc + 1'b1;
    end

    typedef struct {
        int   at;
        logic src;
    } strobe_t;

    strobe_t sb[$];
    strobe_t popped;
    int      vecCount = 0;
    int      missCount = 0;
    logic    prevEn = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (execEnable === 1'b1) begin
            checkEq("backToBack", {31'd0, prevEn}, 0);
            if (sb.size() == 0) begin
                checkEq("spuriousStrobe", {31'd0, execEnable}, 0);
            end else begin
                popped = sb.pop_front();
                checkEq("strobeCycle", cyc, popped.at);
                checkEq("strobeSrc", {31'd0, useBasys}, {31'd0, popped.src});
            end
        end
        prevEn = (execEnable === 1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitTo(input int c);
        if (c > cyc) cycles(c - cyc);
    endtask

    task automatic expectAt(input int c, input logic s);
        strobe_t e;
        e.at  = c;
        e.src = s;
        sb.push_back(e);
    endtask

    task automatic pulse(input int which);
        case (which)
            P_STEP:  stepPulse = 1'b1;
            P_RUN:   runPulse = 1'b1;
            default: basysPulse = 1'b1;
        endcase
        cycles(1);
        stepPulse  = 1'b0;
        runPulse   = 1'b0;
        basysPulse = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, ".state"}, {29'd0, state}, 0);
        checkEq({tag, ".exec"}, {31'd0, execEnable}, 0);
        checkEq({tag, ".basys"}, {31'd0, useBasys}, 0);
        checkEq({tag, ".count"}, {28'd0, instrCount}, 0);
    endtask

    task automatic checkDrained(input string tag);
        checkEq(tag, sb.size(), 0);
    endtask

    int n;

    initial begin
        cycles(1);
        doReset();
        checkResetState("reset");

        // Single step from IDLE.
        n = cyc;
        expectAt(n + 1, 1'b0);
        pulse(P_STEP);
        cycles(2);
        checkEq("stepCount", {28'd0, instrCount}, 1);
        checkEq("stepState", {29'd0, state}, 0);
        checkDrained("stepDrain");

        // Switch-sourced instruction.
        n = cyc;
        expectAt(n + 2, 1'b1);
        pulse(P_BASYS);
        checkEq("basysState", {29'd0, state}, 4);
        checkEq("basysSel1", {31'd0, useBasys}, 1);
        cycles(1);
        checkEq("basysSel2", {31'd0, useBasys}, 1);
        cycles(1);
        checkEq("basysDone", {29'd0, state}, 0);
        checkEq("basysSel3", {31'd0, useBasys}, 0);
        cycles(1);
        checkEq("basysCount", {28'd0, instrCount}, 2);
        checkDrained("basysDrain");

        // Free run, then stop.
        n = cyc;
        for (int k = 0; k < 4; k++) expectAt(n + 5 + TD * k, 1'b0);
        pulse(P_RUN);
        checkEq("runState", {29'd0, state}, 1);
        waitTo(n + 19);
        pulse(P_RUN);
        checkEq("runStop", {29'd0, state}, 0);
        cycles(10);
        checkEq("runCount", {28'd0, instrCount}, 6);
        checkDrained("runDrain");

        // Halt raised before the third tick.
        n = cyc;
        expectAt(n + 5, 1'b0);
        expectAt(n + 9, 1'b0);
        pulse(P_RUN);
        waitTo(n + 10);
        halt = 1'b1;
        cycles(4);
        halt = 1'b0;
        checkEq("haltState", {29'd0, state}, 2);
        pulse(P_STEP);
        cycles(2);
        pulse(P_RUN);
        cycles(2);
        pulse(P_BASYS);
        cycles(6);
        checkEq("haltStuck", {29'd0, state}, 2);
        checkEq("haltBasys", {31'd0, useBasys}, 0);
        checkEq("haltCount", {28'd0, instrCount}, 8);
        checkDrained("haltDrain");
        doReset();
        checkResetState("haltReset");

        // Step onto a halting instruction.
        halt = 1'b1;
        pulse(P_STEP);
        halt = 1'b0;
        cycles(2);
        checkEq("stepHalt", {29'd0, state}, 2);
        checkDrained("stepHaltDrain");
        doReset();

`ifdef EXEC_BREAKPOINT_EN
        // Breakpoint at PC=3, then resume executes it once.
        brk = 5'd3;
        n = cyc;
        for (int k = 0; k < 3; k++) expectAt(n + 5 + TD * k, 1'b0);
        pulse(P_RUN);
        waitTo(n + 18);
        checkEq("bpState", {29'd0, state}, 3);
        checkEq("bpPc", {27'd0, pc}, 3);
        cycles(3);
        checkEq("bpHold", {29'd0, state}, 3);
        n = cyc;
        expectAt(n + 5, 1'b0);
        expectAt(n + 9, 1'b0);
        pulse(P_RUN);
        checkEq("bpResume", {29'd0, state}, 1);
        waitTo(n + 10);
        pulse(P_RUN);
        checkEq("bpStop", {29'd0, state}, 0);
        checkEq("bpPcAfter", {27'd0, pc}, 5);
        cycles(4);
        checkDrained("bpDrain");
        brk = 5'd31;
        doReset();
`endif

        // Counter saturation: 17 strobes into a 4-bit counter.
        n = cyc;
        for (int k = 0; k < 17; k++) expectAt(n + 5 + TD * k, 1'b0);
        pulse(P_RUN);
        waitTo(n + 70);
        pulse(P_RUN);
        cycles(3);
        checkEq("satCount", {28'd0, instrCount}, 15);
        checkDrained("satDrain");
        doReset();

        // Reset while in BASYS cancels the pending strobe.
        pulse(P_BASYS);
        checkEq("rstBasysState", {29'd0, state}, 4);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        checkResetState("rstBasys");
        cycles(4);
        checkEq("rstBasysIdle", {29'd0, state}, 0);
        checkDrained("rstBasysDrain");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
